// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store memory controller:
// access size encodings, FSM states, byte-mask and alignment helpers.
package lsu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic [7:0] size_mask(size_e size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e size, logic [2:0] offset);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return offset[0];
      SZ_W:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

  // Clears the low offset bits so the access falls on its natural boundary.
  function automatic logic [2:0] align_offset(size_e size, logic [2:0] offset);
    case (size)
      SZ_B:    return offset;
      SZ_H:    return {offset[2:1], 1'b0};
      SZ_W:    return {offset[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundles: the execute/writeback request-response channel and the
// single-cycle memory port driven by the controller.
interface lsu_req_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_misalign;

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_misalign
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_misalign
  );
endinterface

interface lsu_mem_if;
  import lsu_pkg::*;

  logic            men;
  logic            mwen;
  logic [XLEN-1:0] raddr;
  logic [XLEN-1:0] waddr;
  logic [XLEN-1:0] wdata;
  logic [7:0]      wmask;
  logic [XLEN-1:0] rdata;

  modport master (
    output men, mwen, raddr, waddr, wdata, wmask,
    input  rdata
  );

  modport slave (
    input  men, mwen, raddr, waddr, wdata, wmask,
    output rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl_load_align.sv
// Extracts the addressed lanes from a memory dword and sign- or
// zero-extends them to a full register value.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  size_e           size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (size)
      SZ_B: result = is_unsigned ? {56'd0, shifted[7:0]}
                                 : {{56{shifted[7]}}, shifted[7:0]};
      SZ_H: result = is_unsigned ? {48'd0, shifted[15:0]}
                                 : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W: result = is_unsigned ? {32'd0, shifted[31:0]}
                                 : {{32{shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store front end: one request at a time, one registered memory
// access cycle, then a held response until the consumer accepts it.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  lsu_req_if.slave req_bus,
  lsu_mem_if.master mem_bus
);

  state_e          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  size_e           size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [2:0]      offset_q, offset_d;
  logic            men_q, men_d;
  logic            mwen_q, mwen_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      wmask_q, wmask_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_misalign_q, resp_misalign_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;

  size_e           req_size;
  logic [2:0]      req_offset;
  logic            req_misaligned;
  logic [XLEN-1:0] load_result;

  assign req_size       = size_e'(req_bus.req_size);
  assign req_offset     = align_offset(req_size, req_bus.req_addr[2:0]);
  assign req_misaligned = MISALIGN_CHECK && is_misaligned(req_size, req_bus.req_addr[2:0]);

  lsu_load_align u_load_align (
    .rdata       (mem_bus.rdata),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (load_result)
  );

  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    offset_d        = offset_q;
    men_d           = men_q;
    mwen_d          = mwen_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    resp_valid_d    = resp_valid_q;
    resp_misalign_d = resp_misalign_q;
    resp_rdata_d    = resp_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          size_d      = req_size;
          unsigned_d  = req_bus.req_unsigned;
          offset_d    = req_offset;
          if (req_misaligned) begin
            state_d         = ST_RESP;
            resp_valid_d    = 1'b1;
            resp_misalign_d = 1'b1;
            resp_rdata_d    = '0;
          end else begin
            state_d = ST_ACCESS;
            men_d   = 1'b1;
            mwen_d  = req_bus.req_wen;
            addr_d  = {req_bus.req_addr[XLEN-1:3], 3'b000};
            if (req_bus.req_wen) begin
              wdata_d = req_bus.req_wdata << {req_offset, 3'b000};
              wmask_d = size_mask(req_size) << req_offset;
            end else begin
              wdata_d = '0;
              wmask_d = '0;
            end
          end
        end
      end

      // Memory data is only valid during the access cycle, so the extended
      // result is captured into the response register on the way out.
      ST_ACCESS: begin
        state_d         = ST_RESP;
        men_d           = 1'b0;
        mwen_d          = 1'b0;
        wmask_d         = '0;
        resp_valid_d    = 1'b1;
        resp_misalign_d = 1'b0;
        resp_rdata_d    = mwen_q ? '0 : load_result;
      end

      ST_RESP: begin
        if (req_bus.resp_ready) begin
          state_d         = ST_IDLE;
          req_ready_d     = 1'b1;
          resp_valid_d    = 1'b0;
          resp_misalign_d = 1'b0;
          resp_rdata_d    = '0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      req_ready_q     <= 1'b1;
      size_q          <= SZ_B;
      unsigned_q      <= 1'b0;
      offset_q        <= 3'd0;
      men_q           <= 1'b0;
      mwen_q          <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_misalign_q <= 1'b0;
      resp_rdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      size_q          <= size_d;
      unsigned_q      <= unsigned_d;
      offset_q        <= offset_d;
      men_q           <= men_d;
      mwen_q          <= mwen_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      resp_valid_q    <= resp_valid_d;
      resp_misalign_q <= resp_misalign_d;
      resp_rdata_q    <= resp_rdata_d;
    end
  end

  assign req_bus.req_ready     = req_ready_q;
  assign req_bus.resp_valid    = resp_valid_q;
  assign req_bus.resp_misalign = resp_misalign_q;
  assign req_bus.resp_rdata    = resp_rdata_q;

  assign mem_bus.men   = men_q;
  assign mem_bus.mwen  = mwen_q;
  assign mem_bus.raddr = addr_q;
  assign mem_bus.waddr = addr_q;
  assign mem_bus.wdata = wdata_q;
  assign mem_bus.wmask = wmask_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a one-dword memory model and
// hand-computed expected values.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst;
  logic [63:0] mem_dword;
  int n_compared;
  int n_mismatched;

  lsu_req_if req_bus ();
  lsu_mem_if mem_bus ();

  lsu_mem_ctrl #(.MISALIGN_CHECK(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_bus (req_bus),
    .mem_bus (mem_bus)
  );

  assign mem_bus.rdata = (mem_bus.raddr == 64'h0000_0000_8000_0000) ? mem_dword : 64'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    end
  endtask

  // Drives one request for a single clock and returns #1 after the accept edge.
  task automatic applyStimulus(input logic wen, input logic [1:0] size, input logic uns,
                               input logic [63:0] addr, input logic [63:0] wd);
    @(negedge clk);
    req_bus.req_valid    = 1'b1;
    req_bus.req_wen      = wen;
    req_bus.req_size     = size;
    req_bus.req_unsigned = uns;
    req_bus.req_addr     = addr;
    req_bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    req_bus.req_valid = 1'b0;
  endtask

  task automatic finishResponse(input string tag);
    @(negedge clk);
    req_bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_bus.resp_ready = 1'b0;
    checkOutput({tag, "_valid_clr"}, 64'(req_bus.resp_valid), 64'h0);
    checkOutput({tag, "_ready_set"}, 64'(req_bus.req_ready), 64'h1);
  endtask

  // Normal load: checks the access cycle, then the response.
  task automatic runLoad(input string tag, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] exp);
    applyStimulus(1'b0, size, uns, addr, 64'h0);
    checkOutput({tag, "_men"}, 64'(mem_bus.men), 64'h1);
    checkOutput({tag, "_mwen"}, 64'(mem_bus.mwen), 64'h0);
    checkOutput({tag, "_raddr"}, mem_bus.raddr, 64'h0000_0000_8000_0000);
    checkOutput({tag, "_wmask"}, 64'(mem_bus.wmask), 64'h0);
    checkOutput({tag, "_rdy_busy"}, 64'(req_bus.req_ready), 64'h0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_men_off"}, 64'(mem_bus.men), 64'h0);
    checkOutput({tag, "_valid"}, 64'(req_bus.resp_valid), 64'h1);
    checkOutput({tag, "_rdata"}, req_bus.resp_rdata, exp);
    checkOutput({tag, "_misal"}, 64'(req_bus.resp_misalign), 64'h0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    mem_dword    = 64'h1122_3344_8566_7788;
    rst          = 1'b1;
    req_bus.req_valid    = 1'b0;
    req_bus.req_wen      = 1'b0;
    req_bus.req_size     = 2'd0;
    req_bus.req_unsigned = 1'b0;
    req_bus.req_addr     = 64'h0;
    req_bus.req_wdata    = 64'h0;
    req_bus.resp_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 64'(req_bus.req_ready), 64'h1);
    checkOutput("rst_valid", 64'(req_bus.resp_valid), 64'h0);
    checkOutput("rst_rdata", req_bus.resp_rdata, 64'h0);
    checkOutput("rst_men", 64'(mem_bus.men), 64'h0);
    checkOutput("rst_wmask", 64'(mem_bus.wmask), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // sb to byte lane 3
    applyStimulus(1'b1, 2'd0, 1'b0, 64'h0000_0000_8000_0003, 64'h0000_0000_0000_00AB);
    checkOutput("sb_men", 64'(mem_bus.men), 64'h1);
    checkOutput("sb_mwen", 64'(mem_bus.mwen), 64'h1);
    checkOutput("sb_waddr", mem_bus.waddr, 64'h0000_0000_8000_0000);
    checkOutput("sb_wmask", 64'(mem_bus.wmask), 64'h08);
    checkOutput("sb_wdata", mem_bus.wdata, 64'h0000_0000_AB00_0000);
    @(posedge clk);
    #1;
    checkOutput("sb_men_off", 64'(mem_bus.men), 64'h0);
    checkOutput("sb_valid", 64'(req_bus.resp_valid), 64'h1);
    checkOutput("sb_rdata", req_bus.resp_rdata, 64'h0);
    checkOutput("sb_misal", 64'(req_bus.resp_misalign), 64'h0);
    finishResponse("sb");

    runLoad("lw", 2'd2, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8566_7788);
    finishResponse("lw");
    runLoad("lwu", 2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_8566_7788);
    finishResponse("lwu");
    runLoad("lb5", 2'd0, 1'b0, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_0033);
    finishResponse("lb5");

    // sh at an odd address never touches memory
    applyStimulus(1'b1, 2'd1, 1'b0, 64'h0000_0000_8000_0003, 64'h0000_0000_0000_BEEF);
    checkOutput("sh_mis_men", 64'(mem_bus.men), 64'h0);
    checkOutput("sh_mis_valid", 64'(req_bus.resp_valid), 64'h1);
    checkOutput("sh_mis_flag", 64'(req_bus.resp_misalign), 64'h1);
    checkOutput("sh_mis_rdata", req_bus.resp_rdata, 64'h0);
    finishResponse("sh_mis");

    // lhu at offset 6 then hold the response back for five cycles
    runLoad("lhu6", 2'd1, 1'b1, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1122);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", 64'(req_bus.resp_valid), 64'h1);
      checkOutput("bp_rdata", req_bus.resp_rdata, 64'h0000_0000_0000_1122);
      checkOutput("bp_ready", 64'(req_bus.req_ready), 64'h0);
      checkOutput("bp_men", 64'(mem_bus.men), 64'h0);
    end
    finishResponse("bp");
    runLoad("ld", 2'd3, 1'b0, 64'h0000_0000_8000_0000, 64'h1122_3344_8566_7788);
    finishResponse("ld");

    // reset in the middle of an sd access
    applyStimulus(1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0000, 64'hDEAD_BEEF_0123_4567);
    checkOutput("sd_men", 64'(mem_bus.men), 64'h1);
    checkOutput("sd_wmask", 64'(mem_bus.wmask), 64'hFF);
    checkOutput("sd_wdata", mem_bus.wdata, 64'hDEAD_BEEF_0123_4567);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_men", 64'(mem_bus.men), 64'h0);
    checkOutput("rstmid_mwen", 64'(mem_bus.mwen), 64'h0);
    checkOutput("rstmid_wmask", 64'(mem_bus.wmask), 64'h0);
    checkOutput("rstmid_wdata", mem_bus.wdata, 64'h0);
    checkOutput("rstmid_raddr", mem_bus.raddr, 64'h0);
    checkOutput("rstmid_ready", 64'(req_bus.req_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("rstmid_novalid", 64'(req_bus.resp_valid), 64'h0);
      checkOutput("rstmid_nomen", 64'(mem_bus.men), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store front end sitting directly upstream of the simulation memory port block. It accepts one load/store request at a time from the execute stage and issues a single-cycle, dword-aligned access on the men/mwen/raddr/waddr/wdata/wmask/rdata port. It generates byte masks and lane-shifted store data, captures and extracts/extends load data, and returns a response to writeback. Misaligned accesses are flagged and never reach memory.

Parameters:
XLEN, 64, data/address width; only 64 is supported.
MISALIGN_CHECK, 1, 1 = flag misaligned accesses; 0 = issue them with the offset truncated to natural alignment.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  ctrl can accept a request
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0=B 1=H 2=W 3=D
req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-justified
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_rdata  out  XLEN  extended load data; 0 for stores/errors
resp_misalign  out  1  request was misaligned, no access made
men  out  1  memory enable
mwen  out  1  memory write enable
raddr  out  XLEN  read address, dword-aligned
waddr  out  XLEN  write address, dword-aligned
wdata  out  XLEN  lane-shifted store data
wmask  out  8  byte-lane write mask
rdata  in  XLEN  full dword from memory, combinational in the access cycle

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_misalign=0; men=mwen=0, raddr=waddr=wdata=0, wmask=0. Async: men/mwen drop immediately on rst assertion.
- men, mwen, raddr, waddr, wdata and wmask are flop outputs, never combinationally decoded. The memory block fires its DPI read/write whenever men is high, so these must not glitch.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid & req_ready, latch size, unsigned and offset=req_addr[2:0].
  - Misaligned (B never; H offset[0]!=0; W offset[1:0]!=0; D offset!=0, with MISALIGN_CHECK=1): go to RESP with resp_misalign=1 and resp_rdata=0. men stays 0.
  - Otherwise go to ACCESS with men=1, mwen=req_wen, raddr=waddr={req_addr[63:3],3'b0}.
  - Stores additionally get wdata=req_wdata<<(8*offset) and wmask=({1,3,15,255}[size])<<offset.
  - Loads get wmask=0, wdata=0.
- ACCESS (exactly one cycle): for loads, capture rdata at the end of the cycle. Go to RESP. men, mwen and wmask clear on entering RESP.
- RESP: resp_valid=1.
  - Loads: resp_rdata = (rdata>>(8*offset)) truncated to the size, then sign-extended, or zero-extended if unsigned or size=D.
  - Stores: resp_rdata=0.
  - Hold all response outputs stable until resp_ready; on resp_valid & resp_ready return to IDLE.
- req_ready=0 in ACCESS and RESP. There is no request overlap, so the next request can be accepted at the earliest in the cycle after the response handshake.
- Latency: accept at edge N, men high during cycle N+1, resp_valid from edge N+2. Misaligned: resp_valid from edge N+1.
- Reset mid-ACCESS: write aborted (men low asynchronously), response discarded. Reset mid-RESP: response dropped.
- req_valid while busy: ignored. The requester must hold it until req_ready.

Decomposition:
- Package lsu_pkg: size encodings SZ_B/SZ_H/SZ_W/SZ_D; state enum ST_IDLE/ST_ACCESS/ST_RESP; function size_mask(size) returning an 8-bit mask; function is_misaligned(size, offset).
- Sub-module lsu_load_align: combinational rdata, offset, size, unsigned -> extended result.

Test Plan:
- sb: addr 0x80000003, wdata 0xAB -> one men cycle with mwen=1, waddr 0x80000000, wmask 0x08, wdata 0x00000000AB000000; response resp_rdata=0, resp_misalign=0.
- lw vs lwu: addr 0x80000000, memory dword 0x1122334485667788.
  - lw (signed) -> resp_rdata 0xFFFFFFFF85667788.
  - lwu -> resp_rdata 0x0000000085667788.
  - Both: raddr 0x80000000, mwen=0.
- lb with offset: addr 0x80000005, same dword -> resp_rdata 0x0000000000000033.
- Misaligned sh: addr 0x80000003 -> men never high, resp_valid one cycle after accept, resp_misalign=1, resp_rdata=0.
- Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0, men=0 throughout. Release -> IDLE, next request accepted.
- Reset mid-ACCESS: assert rst while men=1 during sd -> men drops the same cycle, all outputs return to reset values, no resp_valid.
